// File: rtl/audio_sample_player.sv
// Streams SAMPLE_COUNT bytes from a registered sample memory, one fetch per CLK_DIV-cycle tick,
// presented on a valid/ready handshake. Define AUDIO_PLAYER_LOOP_EN to add the loop input.
module audio_sample_player #(
    parameter int SAMPLE_COUNT = 23490,
    parameter int CLK_DIV      = 6250
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        play,
    input  logic        stop,
`ifdef AUDIO_PLAYER_LOOP_EN
    input  logic        loop,
`endif
    output logic        mem_re,
    output logic [31:0] mem_addr,
    input  logic [7:0]  mem_data,
    output logic [7:0]  sample_out,
    output logic        sample_valid,
    input  logic        sample_ready,
    output logic        busy,
    output logic        done,
    output logic        overrun
);
    localparam int ADDR_W = (SAMPLE_COUNT > 1) ? $clog2(SAMPLE_COUNT) : 1;
    localparam int CNT_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(SAMPLE_COUNT - 1);
    localparam logic [CNT_W-1:0]  TICK_RELOAD = CNT_W'(CLK_DIV - 1);

    typedef enum logic [2:0] {IDLE, WAIT_TICK, READ, CAPTURE, PRESENT} state_t;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] addr;
    logic [CNT_W-1:0]  tick_cnt;
    logic              tick;
    logic              start;
    logic              accept;
    logic              last;
    logic              wrap;

`ifdef AUDIO_PLAYER_LOOP_EN
    assign wrap = loop;
`else
    assign wrap = 1'b0;
`endif

    assign start  = (state == IDLE) && play && !stop;
    assign tick   = (state != IDLE) && (tick_cnt == '0);
    assign accept = (state == PRESENT) && sample_ready && !stop;
    assign last   = (addr == LAST_ADDR);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if ((state != IDLE) && stop) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:      if (start) state_next = WAIT_TICK;
                WAIT_TICK: if (tick) state_next = READ;
                READ:      state_next = CAPTURE;
                CAPTURE:   state_next = PRESENT;
                PRESENT:   if (accept) state_next = (last && !wrap) ? IDLE : WAIT_TICK;
                default:   state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        mem_re       = (state == READ);
        sample_valid = (state == PRESENT);
        busy         = (state != IDLE);
    end

    assign mem_addr = 32'(addr);

    // The tick counter free-runs outside IDLE so the sample period never stretches with back-pressure.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tick_cnt <= '0;
        end else if (start) begin
            tick_cnt <= TICK_RELOAD;
        end else if (state != IDLE) begin
            tick_cnt <= tick ? TICK_RELOAD : tick_cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            addr <= '0;
        end else if (start) begin
            addr <= '0;
        end else if (accept) begin
            addr <= last ? '0 : addr + ADDR_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sample_out <= 8'h00;
        end else if (state == CAPTURE) begin
            sample_out <= mem_data;
        end
    end

    // A tick that lands on an unconsumed sample is dropped, not queued; overrun records it.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            done    <= 1'b0;
            overrun <= 1'b0;
        end else begin
            done <= accept && last && !wrap;
            if (start) begin
                overrun <= 1'b0;
            end else if ((state == PRESENT) && tick && !sample_ready) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_audio_sample_player.sv
// Self-checking bench for audio_sample_player with SAMPLE_COUNT=4, CLK_DIV=4 and a registered
// memory model; directed scenarios plus randomized back-pressure against a timing reference model.
module tb_audio_sample_player;
    localparam int SC = 4;
    localparam int CD = 4;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        play;
    logic        stop;
    logic        mem_re;
    logic [31:0] mem_addr;
    logic [7:0]  mem_data = 8'h00;
    logic [7:0]  sample_out;
    logic        sample_valid;
    logic        sample_ready;
    logic        busy;
    logic        done;
    logic        overrun;
`ifdef AUDIO_PLAYER_LOOP_EN
    logic        loop = 1'b0;
`endif

    logic [7:0] mem [SC];
    int n_checks = 0;
    int n_fail   = 0;

    audio_sample_player #(.SAMPLE_COUNT(SC), .CLK_DIV(CD)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .play         (play),
        .stop         (stop),
`ifdef AUDIO_PLAYER_LOOP_EN
        .loop         (loop),
`endif
        .mem_re       (mem_re),
        .mem_addr     (mem_addr),
        .mem_data     (mem_data),
        .sample_out   (sample_out),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .busy         (busy),
        .done         (done),
        .overrun      (overrun)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (mem_re) mem_data <= mem[mem_addr % SC];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    // Leaves the caller in cycle 0, the first cycle after play was sampled.
    task automatic play_start();
        play = 1'b1;
        cyc();
        play = 1'b0;
    endtask

    task automatic abort();
        stop = 1'b1;
        cyc();
        stop = 1'b0;
    endtask

    initial begin
        int nvalid, re_cyc, last_valid, done_cnt, re_addr;
        logic prev_re, got_stop, re2_seen;

        reset_n = 1'b0;
        play = 1'b0;
        stop = 1'b0;
        sample_ready = 1'b1;
        mem = '{8'h11, 8'h22, 8'h33, 8'h44};
        #2;
        check("rst_busy", busy, 0);
        check("rst_valid", sample_valid, 0);
        check("rst_re", mem_re, 0);
        check("rst_done", done, 0);
        check("rst_ovr", overrun, 0);
        check("rst_out", sample_out, 0);
        check("rst_addr", mem_addr, 0);
        #11 reset_n = 1'b1;
        cyc();

        // Basic playback with sample_ready tied high
        play_start();
        check("busy_run", busy, 1);
        nvalid = 0; re_cyc = -100; last_valid = -100; done_cnt = 0; re_addr = 0; prev_re = 1'b0;
        for (int n = 0; n < 24; n++) begin
            if (mem_re) begin
                check("re_single", prev_re, 0);
                check("re_addr", mem_addr, nvalid);
                re_cyc = n;
                re_addr = int'(mem_addr);
            end
            if (sample_valid) begin
                check("latency", n - re_cyc, 2);
                check("data_vs_mem", sample_out, mem[re_addr % SC]);
                check("seq", sample_out, 8'h11 * (nvalid + 1));
                if (nvalid > 0) check("period", n - last_valid, CD);
                else check("first_valid", n, 6);
                last_valid = n;
                nvalid++;
            end
            if (done) done_cnt++;
            prev_re = mem_re;
            cyc();
        end
        check("n_samples", nvalid, SC);
        check("done_once", done_cnt, 1);
        check("busy_end", busy, 0);

        // Back-pressure on the first sample across two ticks
        play_start();
        re2_seen = 1'b0;
        for (int n = 0; n < 18; n++) begin
            sample_ready = (n < 6 || n > 11);
            if (n >= 6 && n <= 11) begin
                check("hold_valid", sample_valid, 1);
                check("hold_data", sample_out, 8'h11);
            end
            if (n == 7) check("ovr_before", overrun, 0);
            if (n == 8) check("ovr_set", overrun, 1);
            if (mem_re && n > 4) begin
                check("re2_cycle", n, 16);
                check("re2_addr", mem_addr, 1);
                re2_seen = 1'b1;
            end
            cyc();
        end
        check("re2_seen", re2_seen, 1);
        abort();
        check("stop_busy", busy, 0);
        check("ovr_retained", overrun, 1);

        // Stop while the second sample is presented
        sample_ready = 1'b1;
        play_start();
        check("ovr_clr", overrun, 0);
        got_stop = 1'b0;
        done_cnt = 0;
        for (int n = 0; n < 40 && !got_stop; n++) begin
            if (done) done_cnt++;
            if (sample_valid && sample_out == 8'h22) begin
                sample_ready = 1'b0;
                abort();
                got_stop = 1'b1;
                check("stop_valid", sample_valid, 0);
                check("stop_busy2", busy, 0);
            end else begin
                cyc();
            end
        end
        check("stop_seen", got_stop, 1);
        for (int n = 0; n < 6; n++) begin
            if (done) done_cnt++;
            cyc();
        end
        check("no_done", done_cnt, 0);

        // Asynchronous reset in the middle of WAIT_TICK
        sample_ready = 1'b1;
        play_start();
        repeat (7) cyc();
        check("pre_rst_addr", mem_addr, 1);
        check("pre_rst_busy", busy, 1);
        #1 reset_n = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_valid", sample_valid, 0);
        check("arst_re", mem_re, 0);
        check("arst_done", done, 0);
        check("arst_ovr", overrun, 0);
        check("arst_out", sample_out, 0);
        check("arst_addr", mem_addr, 0);
        #2 reset_n = 1'b1;
        for (int n = 0; n < 3; n++) begin
            cyc();
            check("idle_after_rst", busy, 0);
        end
        play_start();
        re2_seen = 1'b0;
        for (int n = 0; n < 8; n++) begin
            if (mem_re) begin
                check("restart_re_cyc", n, 4);
                check("restart_addr", mem_addr, 0);
                re2_seen = 1'b1;
            end
            if (n == 6) check("restart_data", sample_out, 8'h11);
            cyc();
        end
        check("restart_re_seen", re2_seen, 1);
        abort();

`ifdef AUDIO_PLAYER_LOOP_EN
        // Looping wraps after the last sample without a done pulse
        loop = 1'b1;
        sample_ready = 1'b1;
        play_start();
        nvalid = 0;
        done_cnt = 0;
        for (int n = 0; n < 60 && nvalid < 6; n++) begin
            if (sample_valid) begin
                check("loop_seq", sample_out, 8'h11 * ((nvalid % SC) + 1));
                nvalid++;
            end
            if (done) done_cnt++;
            cyc();
        end
        check("loop_count", nvalid, 6);
        check("loop_no_done", done_cnt, 0);
        abort();
        loop = 1'b0;
`endif

        // Randomized contents and back-pressure against a tick-based reference model
        for (int it = 0; it < 4; it++) begin
            int nacc;
            logic exp_ovr, prev_valid, prev_rdy, seen_done;
            logic [7:0] prev_data;
            for (int i = 0; i < SC; i++) mem[i] = 8'($urandom);
            nacc = 0; exp_ovr = 1'b0; prev_valid = 1'b0; prev_rdy = 1'b0; prev_data = 8'h00;
            seen_done = 1'b0;
            sample_ready = 1'b0;
            play_start();
            for (int n = 0; n < 200 && !seen_done; n++) begin
                sample_ready = ($urandom_range(0, 99) < 40);
                check("rnd_ovr", overrun, exp_ovr);
                if (mem_re) begin
                    check("rnd_re_after_tick", (n % CD == 0) && (n > 0), 1);
                    check("rnd_re_addr", mem_addr, nacc);
                end
                if (prev_valid && !prev_rdy) begin
                    check("rnd_hold_valid", sample_valid, 1);
                    check("rnd_hold_data", sample_out, prev_data);
                end
                if (((n + 1) % CD == 0) && sample_valid && !sample_ready) exp_ovr = 1'b1;
                if (sample_valid && sample_ready) begin
                    check("rnd_data", sample_out, mem[nacc % SC]);
                    nacc++;
                end
                if (done) begin
                    check("rnd_done_count", nacc, SC);
                    check("rnd_done_idle", busy, 0);
                    seen_done = 1'b1;
                end
                prev_valid = sample_valid;
                prev_rdy = sample_ready;
                prev_data = sample_out;
                cyc();
            end
            check("rnd_done_seen", seen_done, 1);
            if (busy) abort();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
